bcd_to_bin: RTL

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bcd_to_bin.sv | 101 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD <-> binary converter family.
package bcd_pkg;

  localparam int NDIG   = 4;          // packed BCD digits
  localparam int BCD_W  = 4 * NDIG;   // 16-bit BCD field
  localparam int BIN_W  = 14;         // binary result width, 0..9999
  localparam int NSHIFT = 16;         // one shift per BCD bit
  localparam int CNT_W  = 5;          // shift counter width

  // The binary landing field must be as wide as the shift count, otherwise
  // the last shifts push result bits out of the bottom of the work register.
  localparam int BINF_W = NSHIFT;
  localparam int WORK_W = BCD_W + BINF_W;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    ADJUST = 2'b10,
    DONE   = 2'b11
  } state_t;

  // True when any packed nibble holds A..F.
  function automatic logic bcd_has_invalid(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits >= 8 lose 3.
// Subtraction wraps modulo 16 and never borrows from a neighbour digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// One conversion takes 16 shifts interleaved with 15 digit corrections; the
// result is registered in DONE, 32 edges after the capturing edge.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG = bcd_pkg::NDIG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [BCD_W-1:0] bcd_in,
  output logic [BIN_W-1:0] bin_out,
  output logic             rdy,
  output logic             busy,
  output logic             err
);

  state_t              state;
  state_t              state_nxt;
  logic [WORK_W-1:0]   work;
  logic [CNT_W-1:0]    shift_cnt;
  logic                invalid;
  logic [BCD_W-1:0]    bcd_adj;
  logic                start;
  logic                last_shift;

  // The cycle in which rdy is high is a recovery cycle: en is not sampled,
  // which makes the start-to-start period 34 cycles when en is held high.
  assign start      = (state == IDLE) && en && !rdy;
  assign last_shift = (shift_cnt == CNT_W'(NSHIFT - 1));

  // Per-digit conditional subtract, all digits in parallel.
  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work[BINF_W + 4*i +: 4]),
      .dout (bcd_adj[4*i +: 4])
    );
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; unreachable encodings fall back to IDLE.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   state_nxt = last_shift ? DONE : ADJUST;
      ADJUST:  state_nxt = SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Work register, shift counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work      <= '0;
      shift_cnt <= '0;
      invalid   <= 1'b0;
      bin_out   <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= {bcd_in, {BINF_W{1'b0}}};
            shift_cnt <= '0;
            invalid   <= bcd_has_invalid(bcd_in);
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          work      <= work >> 1;
          shift_cnt <= shift_cnt + CNT_W'(1);
        end
        ADJUST: begin
          work[WORK_W-1:BINF_W] <= bcd_adj;
        end
        DONE: begin
          bin_out <= invalid ? '0 : work[BIN_W-1:0];
          err     <= invalid;
          rdy     <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
